// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow output.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/ready request side and valid/ack result side of serial_sub.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_start;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             out_valid;
    logic             out_ack;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_start, x, y, bin, out_ack,
        input  in_ready, d, bout, out_valid, ovf
    );
    modport slave (
        input  in_start, x, y, bin, out_ack,
        output in_ready, d, bout, out_valid, ovf
    );
`else
    modport master (
        output in_start, x, y, bin, out_ack,
        input  in_ready, d, bout, out_valid
    );
    modport slave (
        input  in_start, x, y, bin, out_ack,
        output in_ready, d, bout, out_valid
    );
`endif
endinterface

// File: rtl/serial_sub_fsub_cell.sv
// Combinational 1-bit full subtractor: a - b - bin.
module fsub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed overflow flag.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d;
    logic             bout_q, bout_d;
    logic             cell_d, cell_b;
    logic             last;

    fsub_cell u_cell (
        .a_i    (xs_q[0]),
        .b_i    (ys_q[0]),
        .bin_i  (b_q),
        .d_o    (cell_d),
        .bout_o (cell_b)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
    logic xm_q, xm_d, ym_q, ym_d, ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        d_d     = d_q;
        b_d     = b_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        xm_d    = xm_q;
        ym_d    = ym_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_start) begin
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    b_d     = bus.bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    xm_d    = bus.x[WIDTH-1];
                    ym_d    = bus.y[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                d_d  = {cell_d, d_q[WIDTH-1:1]};
                xs_d = {1'b0, xs_q[WIDTH-1:1]};
                ys_d = {1'b0, ys_q[WIDTH-1:1]};
                b_d  = cell_b;
                // Counter stops at WIDTH-1 so it never wraps
                if (last) begin
                    state_d = DONE;
                    bout_d  = cell_b;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (xm_q ^ ym_q) & (cell_d ^ xm_q);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            d_q     <= '0;
            b_q     <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            d_q     <= d_d;
            b_q     <= b_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xm_q  <= 1'b0;
            ym_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            xm_q  <= xm_d;
            ym_q  <= ym_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub at WIDTH 4, 8 and 16 against an arithmetic model.
// Overflow vectors run only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x_s = '0;
    logic [31:0] y_s = '0;
    logic        bin_s = 1'b0;
    logic        ack_s = 1'b0;
    logic        st4 = 1'b0;
    logic        st8 = 1'b0;
    logic        st16 = 1'b0;
    logic        last_ovf = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(4))  i4 ();
    serial_sub_if #(.WIDTH(8))  i8 ();
    serial_sub_if #(.WIDTH(16)) i16 ();

    assign i4.x = x_s[3:0];
    assign i4.y = y_s[3:0];
    assign i4.bin = bin_s;
    assign i4.out_ack = ack_s;
    assign i4.in_start = st4;
    assign i8.x = x_s[7:0];
    assign i8.y = y_s[7:0];
    assign i8.bin = bin_s;
    assign i8.out_ack = ack_s;
    assign i8.in_start = st8;
    assign i16.x = x_s[15:0];
    assign i16.y = y_s[15:0];
    assign i16.bin = bin_s;
    assign i16.out_ack = ack_s;
    assign i16.in_start = st16;

    serial_sub #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
    serial_sub #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    serial_sub #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic get_valid(input int w);
        case (w)
            4: return i4.out_valid;
            8: return i8.out_valid;
            default: return i16.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int w);
        case (w)
            4: return i4.in_ready;
            8: return i8.in_ready;
            default: return i16.in_ready;
        endcase
    endfunction

    function automatic logic get_bout(input int w);
        case (w)
            4: return i4.bout;
            8: return i8.bout;
            default: return i16.bout;
        endcase
    endfunction

    function automatic logic [31:0] get_d(input int w);
        case (w)
            4: return 32'(i4.d);
            8: return 32'(i8.d);
            default: return 32'(i16.d);
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            4: st4 = v;
            8: st8 = v;
            default: st16 = v;
        endcase
    endtask

    // Reference: plain modular arithmetic and unsigned compare
    function automatic logic [31:0] ref_d(input int w, input logic [31:0] xv,
                                          input logic [31:0] yv, input logic bv);
        longint r;
        r = longint'(xv) - longint'(yv) - longint'(bv);
        r = r & ((64'd1 << w) - 1);
        return 32'(r);
    endfunction

    function automatic logic ref_b(input logic [31:0] xv, input logic [31:0] yv,
                                   input logic bv);
        return longint'(xv) < (longint'(yv) + longint'(bv));
    endfunction

    task automatic op(input int w, input logic [31:0] xv, input logic [31:0] yv,
                      input logic bv, output logic [31:0] dv, output logic bo,
                      output int lat);
        x_s = xv;
        y_s = yv;
        bin_s = bv;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        lat = -1;
        for (int k = 1; k <= 4 * w + 8; k++) begin
            @(posedge clk);
            #1;
            if (get_valid(w)) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout w=%0d: out_valid never rose", w);
        end
        dv = get_d(w);
        bo = get_bout(w);
`ifdef SERIAL_SUB_OVF_EN
        last_ovf = i8.ovf;
`endif
        ack_s = 1'b1;
        @(posedge clk);
        #1;
        ack_s = 1'b0;
    endtask

    task automatic run_chk(input string tag, input int w, input logic [31:0] xv,
                           input logic [31:0] yv, input logic bv);
        logic [31:0] dv;
        logic bo;
        int lat;
        op(w, xv, yv, bv, dv, bo, lat);
        chk({tag, " lat"}, 32'(lat), 32'(w));
        chk({tag, " d"}, dv, ref_d(w, xv, yv, bv));
        chk({tag, " bout"}, 32'(bo), 32'(ref_b(xv, yv, bv)));
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       bin;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] dv;
        logic bo;
        int lat;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
        tbl[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

        #2;
        chk("rst ready", 32'(i8.in_ready), 32'd1);
        chk("rst valid", 32'(i8.out_valid), 32'd0);
        chk("rst d", get_d(8), 32'd0);
        chk("rst bout", 32'(i8.bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            chk($sformatf("tbl%0d ready_before", i), 32'(get_ready(8)), 32'd1);
            op(8, 32'(tbl[i].x), 32'(tbl[i].y), tbl[i].bin, dv, bo, lat);
            chk($sformatf("tbl%0d lat", i), 32'(lat), 32'd8);
            chk($sformatf("tbl%0d d", i), dv, 32'(tbl[i].ed));
            chk($sformatf("tbl%0d bout", i), 32'(bo), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d ready_after_ack", i), 32'(get_ready(8)), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("tbl%0d ovf", i), 32'(last_ovf), 32'(tbl[i].eo));
`endif
        end

        // Backpressure: result held, start ignored until ack
        x_s = 32'hFF;
        y_s = 32'hFF;
        bin_s = 1'b1;
        st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d valid", i), 32'(i8.out_valid), 32'd1);
            chk($sformatf("bp%0d d", i), get_d(8), 32'hFF);
            chk($sformatf("bp%0d bout", i), 32'(i8.bout), 32'd1);
            chk($sformatf("bp%0d ready", i), 32'(i8.in_ready), 32'd0);
            st8 = (i % 2 == 0);
            x_s = 32'h12;
            @(posedge clk);
            #1;
        end
        st8 = 1'b0;
        chk("bp end valid", 32'(i8.out_valid), 32'd1);
        chk("bp end d", get_d(8), 32'hFF);
        ack_s = 1'b1;
        @(posedge clk);
        #1;
        ack_s = 1'b0;
        chk("bp ack ready", 32'(i8.in_ready), 32'd1);
        chk("bp ack valid", 32'(i8.out_valid), 32'd0);
        chk("bp ack d kept", get_d(8), 32'hFF);
        chk("bp ack bout kept", 32'(i8.bout), 32'd1);

        // Reset mid-operation aborts asynchronously
        x_s = 32'hAA;
        y_s = 32'h55;
        bin_s = 1'b0;
        st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid ready", 32'(i8.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort valid", 32'(i8.out_valid), 32'd0);
        chk("abort ready", 32'(i8.in_ready), 32'd1);
        chk("abort d", get_d(8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_chk("post_rst", 8, 32'h10, 32'h01, 1'b0);

        for (int v = 0; v < 512; v++) begin
            run_chk($sformatf("w4 %0d", v), 4, 32'(v[7:4]), 32'(v[3:0]), v[8]);
        end

        for (int v = 0; v < 1000; v++) begin
            run_chk($sformatf("w16 %0d", v), 16, 32'($urandom_range(0, 65535)),
                    32'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
